one_addr_serializer: RTL and testbench
======================================

ONE_ADDR_SERIALIZER -- requirements
Module: one_addr_serializer

Interface
REQ-001 SHALL have parameter N, default 5, input vector width in bits (N >= 2).
REQ-002 SHALL have parameter WIDTH, default $clog2(N), address width.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = emit addresses lowest index first, 1 = highest index first.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port data  input  N  bit vector to scan, sampled on accept.
REQ-007 SHALL have port vld_i  input  1  input valid.
REQ-008 SHALL have port rdy_i  output  1  input ready; accept = vld_i & rdy_i on a rising edge.
REQ-009 SHALL have port addr  output  WIDTH  index of current set bit.
REQ-010 SHALL have port vld_o  output  1  addr valid.
REQ-011 SHALL have port rdy_o  input  1  downstream ready; transfer = vld_o & rdy_o.
REQ-012 SHALL have port last_o  output  1  high with vld_o when addr is the final set bit of the vector.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse when a vector finishes (last transfer, or zero vector).
REQ-014 SHALL have port cnt_o  output  WIDTH+1  set-bit count of the accepted vector (present only under ONE_ADDR_CNT_EN).

Function
REQ-015 SHALL implement states IDLE and SCAN; reset state IDLE.
REQ-016 SHALL drive rdy_i=1 in IDLE, 0 in SCAN; vld_i while in SCAN is ignored and data is not sampled.
REQ-017 SHALL, on accept with data!=0, latch data into mask register and enter SCAN next cycle.
REQ-018 SHALL, on accept with data==0, stay in IDLE, assert done_o for exactly the next cycle, and never assert vld_o.
REQ-019 SHALL in SCAN assert vld_o and drive addr = index of lowest (MSB_FIRST=0) or highest (MSB_FIRST=1) set bit of mask.
REQ-020 SHALL hold addr, vld_o, last_o stable while vld_o & !rdy_o (backpressure, no bit skipped).
REQ-021 SHALL on each transfer clear the emitted bit in mask; next address valid the following cycle (throughput one address per cycle with rdy_o=1).
REQ-022 SHALL assert last_o when mask has exactly one set bit.
REQ-023 SHALL on transfer with last_o=1 return to IDLE, deassert vld_o and assert rdy_i next cycle, and pulse done_o that same next cycle.
REQ-024 SHALL make first vld_o rise one cycle after accept; data = all ones emits N addresses, last at N-1 (or 0 when MSB_FIRST).
REQ-025 SHALL drive addr=0 and last_o=0 whenever vld_o=0.
REQ-026 SHALL never present an addr >= N.

Reset
REQ-027 SHALL on rst_n=0 immediately clear state to IDLE, mask to 0, vld_o=0, last_o=0, done_o=0, addr=0, cnt_o=0, rdy_i=1.
REQ-028 SHALL abandon any in-progress vector on reset mid-SCAN; no further addresses of it are emitted after rst_n rises.

Configuration
REQ-029 SHALL, with ONE_ADDR_CNT_EN defined, add port cnt_o, registered on accept with popcount(data) and held until next accept; 0 for zero vector.
REQ-030 SHALL, without ONE_ADDR_CNT_EN, omit cnt_o and its popcount logic; all other behaviour identical.

Verification
REQ-031 SHALL check N=5, MSB_FIRST=0, rdy_o=1, data=5'b10110 -> addr 1,2,4 on consecutive cycles, last_o on 4, done_o next cycle, cnt_o=3.
REQ-032 SHALL check data=5'b00000 accepted -> no vld_o, done_o one cycle, rdy_i stays 1, cnt_o=0.
REQ-033 SHALL check data=5'b11111 with rdy_o toggling 1,0,0,1,... -> exactly 0,1,2,3,4 emitted, each held stable during stalls.
REQ-034 SHALL check MSB_FIRST=1, data=5'b01001 -> addr 3 then 0 (last_o), vld_i=1 with new data during SCAN ignored.
REQ-035 SHALL check rst_n pulse after first transfer of 5'b11100 -> vld_o=0 asynchronously, rdy_i=1, no address 3 or 4 afterwards.
REQ-036 SHALL check exhaustive sweep data=1..31 -> emitted address set equals set-bit positions, count matches cnt_o.

Source files
------------

// File: rtl/one_addr_serializer.sv
// ============================================================================
// Module      : one_addr_serializer
// Description : Accepts an N-bit vector and emits the index of every set bit,
//               one per transfer, lowest or highest index first. The optional
//               set-bit count output cnt_o is enabled by the ONE_ADDR_CNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module one_addr_serializer #(
    parameter int N         = 5,
    parameter int WIDTH     = $clog2(N),
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     data,
    input  logic             vld_i,
    output logic             rdy_i,
    output logic [WIDTH-1:0] addr,
    output logic             vld_o,
    input  logic             rdy_o,
    output logic             last_o,
    output logic             done_o
`ifdef ONE_ADDR_CNT_EN
    ,
    output logic [WIDTH:0]   cnt_o
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_mask;
    logic [N-1:0]     w_next_mask;
    logic             w_accept;
    logic             w_xfer;

    // Priority pick: the last match written wins, so loop direction sets the order.
    function automatic logic [WIDTH-1:0] pick_index(input logic [N-1:0] vec);
        logic [WIDTH-1:0] idx;
        idx = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = WIDTH'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = WIDTH'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [N-1:0] vec);
        return (vec != '0) && ((vec & (vec - N'(1))) == '0);
    endfunction

`ifdef ONE_ADDR_CNT_EN
    function automatic logic [WIDTH:0] popcount(input logic [N-1:0] vec);
        logic [WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{WIDTH{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction
`endif

    assign w_accept = vld_i & rdy_i;
    assign w_xfer   = vld_o & rdy_o;

    // Mask with the currently presented bit removed.
    always_comb begin
        w_next_mask = r_mask;
        for (int i = 0; i < N; i++) begin
            if (addr == WIDTH'(i)) w_next_mask[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mask  <= '0;
            rdy_i   <= 1'b1;
            addr    <= '0;
            vld_o   <= 1'b0;
            last_o  <= 1'b0;
            done_o  <= 1'b0;
`ifdef ONE_ADDR_CNT_EN
            cnt_o   <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
`ifdef ONE_ADDR_CNT_EN
                        cnt_o <= popcount(data);
`endif
                        if (data != '0) begin
                            r_mask  <= data;
                            r_state <= SCAN;
                            rdy_i   <= 1'b0;
                            vld_o   <= 1'b1;
                            addr    <= pick_index(data);
                            last_o  <= is_single(data);
                        end else begin
                            done_o  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (w_xfer) begin
                        if (last_o) begin
                            r_state <= IDLE;
                            r_mask  <= '0;
                            rdy_i   <= 1'b1;
                            vld_o   <= 1'b0;
                            addr    <= '0;
                            last_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            r_mask  <= w_next_mask;
                            addr    <= pick_index(w_next_mask);
                            last_o  <= is_single(w_next_mask);
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_one_addr_serializer.sv
// ============================================================================
// Module      : tb_one_addr_serializer
// Description : Directed self-checking bench for one_addr_serializer, with an
//               LSB-first and an MSB-first instance side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_one_addr_serializer;

    localparam int C_N = 5;
    localparam int C_W = 3;

    logic           clk = 1'b0;
    logic           rst_n;

    logic [C_N-1:0] d0_data, d1_data;
    logic           d0_vld_i, d1_vld_i;
    logic           d0_rdy_i, d1_rdy_i;
    logic [C_W-1:0] d0_addr, d1_addr;
    logic           d0_vld_o, d1_vld_o;
    logic           d0_rdy_o, d1_rdy_o;
    logic           d0_last_o, d1_last_o;
    logic           d0_done_o, d1_done_o;
`ifdef ONE_ADDR_CNT_EN
    logic [C_W:0]   d0_cnt_o, d1_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    one_addr_serializer #(.N(C_N), .MSB_FIRST(0)) u_lsb (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (d0_data),
        .vld_i  (d0_vld_i),
        .rdy_i  (d0_rdy_i),
        .addr   (d0_addr),
        .vld_o  (d0_vld_o),
        .rdy_o  (d0_rdy_o),
        .last_o (d0_last_o),
        .done_o (d0_done_o)
`ifdef ONE_ADDR_CNT_EN
        ,
        .cnt_o  (d0_cnt_o)
`endif
    );

    one_addr_serializer #(.N(C_N), .MSB_FIRST(1)) u_msb (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (d1_data),
        .vld_i  (d1_vld_i),
        .rdy_i  (d1_rdy_i),
        .addr   (d1_addr),
        .vld_o  (d1_vld_o),
        .rdy_o  (d1_rdy_o),
        .last_o (d1_last_o),
        .done_o (d1_done_o)
`ifdef ONE_ADDR_CNT_EN
        ,
        .cnt_o  (d1_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int            exp_idx;
    int            guard;
    logic [31:0]   seen;
    int            n_seen;
    logic          rdy_pat [4];

    initial begin
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        rst_n    = 1'b0;
        d0_data  = '0; d0_vld_i = 1'b0; d0_rdy_o = 1'b1;
        d1_data  = '0; d1_vld_i = 1'b0; d1_rdy_o = 1'b1;
        step();
        chk("rst_rdy_i",  32'(d0_rdy_i),  32'd1);
        chk("rst_vld_o",  32'(d0_vld_o),  32'd0);
        chk("rst_addr",   32'(d0_addr),   32'd0);
        chk("rst_last_o", 32'(d0_last_o), 32'd0);
        chk("rst_done_o", 32'(d0_done_o), 32'd0);
`ifdef ONE_ADDR_CNT_EN
        chk("rst_cnt_o",  32'(d0_cnt_o),  32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Sparse vector 10110 -> 1, 2, 4
        d0_data = 5'b10110; d0_vld_i = 1'b1; d0_rdy_o = 1'b1;
        step();
        d0_vld_i = 1'b0;
        chk("v1_vld0",  32'(d0_vld_o),  32'd1);
        chk("v1_addr0", 32'(d0_addr),   32'd1);
        chk("v1_last0", 32'(d0_last_o), 32'd0);
        chk("v1_rdy_i", 32'(d0_rdy_i),  32'd0);
        step();
        chk("v1_addr1", 32'(d0_addr),   32'd2);
        chk("v1_last1", 32'(d0_last_o), 32'd0);
        step();
        chk("v1_addr2", 32'(d0_addr),   32'd4);
        chk("v1_last2", 32'(d0_last_o), 32'd1);
        step();
        chk("v1_vld_end",  32'(d0_vld_o),  32'd0);
        chk("v1_done",     32'(d0_done_o), 32'd1);
        chk("v1_rdy_end",  32'(d0_rdy_i),  32'd1);
        chk("v1_addr_end", 32'(d0_addr),   32'd0);
`ifdef ONE_ADDR_CNT_EN
        chk("v1_cnt", 32'(d0_cnt_o), 32'd3);
`endif
        step();
        chk("v1_done_pulse", 32'(d0_done_o), 32'd0);

        // Zero vector
        d0_data = 5'b00000; d0_vld_i = 1'b1;
        step();
        d0_vld_i = 1'b0;
        chk("z_vld",  32'(d0_vld_o),  32'd0);
        chk("z_done", 32'(d0_done_o), 32'd1);
        chk("z_rdy",  32'(d0_rdy_i),  32'd1);
`ifdef ONE_ADDR_CNT_EN
        chk("z_cnt",  32'(d0_cnt_o),  32'd0);
`endif
        step();
        chk("z_done_pulse", 32'(d0_done_o), 32'd0);
        chk("z_vld2",       32'(d0_vld_o),  32'd0);

        // All ones under backpressure pattern 1,0,0,1
        d0_data = 5'b11111; d0_vld_i = 1'b1;
        step();
        d0_vld_i = 1'b0;
        exp_idx = 0;
        for (int cyc = 0; cyc < 30 && exp_idx < 5; cyc++) begin
            d0_rdy_o = rdy_pat[cyc % 4];
            chk("bp_vld",  32'(d0_vld_o),  32'd1);
            chk("bp_addr", 32'(d0_addr),   32'(exp_idx));
            chk("bp_last", 32'(d0_last_o), (exp_idx == 4) ? 32'd1 : 32'd0);
            step();
            if (d0_rdy_o) exp_idx++;
        end
        chk("bp_count", 32'(exp_idx),   32'd5);
        chk("bp_vld_end", 32'(d0_vld_o), 32'd0);
        chk("bp_done",  32'(d0_done_o), 32'd1);
        d0_rdy_o = 1'b1;
        step();

        // MSB-first 01001 -> 3, 0 with new input during SCAN ignored
        d1_data = 5'b01001; d1_vld_i = 1'b1; d1_rdy_o = 1'b1;
        step();
        chk("m_addr0", 32'(d1_addr),   32'd3);
        chk("m_vld0",  32'(d1_vld_o),  32'd1);
        chk("m_last0", 32'(d1_last_o), 32'd0);
        d1_data = 5'b11111;
        step();
        d1_vld_i = 1'b0;
        chk("m_addr1", 32'(d1_addr),   32'd0);
        chk("m_last1", 32'(d1_last_o), 32'd1);
        step();
        chk("m_vld_end", 32'(d1_vld_o),  32'd0);
        chk("m_done",    32'(d1_done_o), 32'd1);
        chk("m_rdy",     32'(d1_rdy_i),  32'd1);
`ifdef ONE_ADDR_CNT_EN
        chk("m_cnt",     32'(d1_cnt_o),  32'd2);
`endif
        step();
        chk("m_ignored", 32'(d1_vld_o),  32'd0);

        // Reset mid-SCAN on 11100
        d0_data = 5'b11100; d0_vld_i = 1'b1; d0_rdy_o = 1'b1;
        step();
        d0_vld_i = 1'b0;
        chk("r_addr0", 32'(d0_addr), 32'd2);
        step();
        chk("r_addr1", 32'(d0_addr), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_vld",  32'(d0_vld_o),  32'd0);
        chk("r_async_rdy",  32'(d0_rdy_i),  32'd1);
        chk("r_async_addr", 32'(d0_addr),   32'd0);
        chk("r_async_last", 32'(d0_last_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("r_no_resume", 32'(d0_vld_o), 32'd0);
        end

        // Sweep 1..31
        for (int v = 1; v < 32; v++) begin
            d0_data = 5'(v); d0_vld_i = 1'b1;
            step();
            d0_vld_i = 1'b0;
            seen = '0; n_seen = 0; guard = 0;
            while (d0_vld_o && guard < 10) begin
                seen[d0_addr] = 1'b1;
                n_seen++;
                guard++;
                step();
            end
            chk("sw_bound", 32'(guard < 10),   32'd1);
            chk("sw_set",   seen,              32'(v));
            chk("sw_count", 32'(n_seen),       32'($countones(v)));
            chk("sw_done",  32'(d0_done_o),    32'd1);
`ifdef ONE_ADDR_CNT_EN
            chk("sw_cnt",   32'(d0_cnt_o),     32'($countones(v)));
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
